ram_sequencer: RTL and testbench
================================

RAM_SEQUENCER -- requirements
Module: ram_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port address, input, ADDR_W, user read/write address.
REQ-006 The block SHALL have port data, input, DATA_W, user write data.
REQ-007 The block SHALL have port wren, input, 1, user write enable.
REQ-008 The block SHALL have port fill_start, input, 1, one-cycle request to fill the whole array.
REQ-009 The block SHALL have port fill_value, input, DATA_W, value written by a fill; sampled on the accepted fill_start cycle.
REQ-010 The block SHALL have port scan_en, input, 1, selects the internal scan counter as read address.
REQ-011 The block SHALL have port tick, input, 1, scan-advance strobe.
REQ-012 The block SHALL have port q, output, DATA_W, registered read data.
REQ-013 The block SHALL have port q_addr, output, ADDR_W, address that produced the current q.
REQ-014 The block SHALL have port busy, output, 1, high while in FILL.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse when a fill completes.

Function
REQ-016 The read address SHALL be the scan counter when scan_en=1, otherwise address.
REQ-017 q and q_addr SHALL update one cycle after the read address is presented (latency 1).
REQ-018 In IDLE, wren=1 SHALL write data to address at the clock edge.
REQ-019 Read-during-write to the same address SHALL return the old word (see REQ-031 for the alternative).
REQ-020 The FSM SHALL have states IDLE and FILL; IDLE->FILL on fill_start=1; FILL->IDLE after writing address DEPTH-1.
REQ-021 FILL SHALL write the latched fill_value to addresses 0..DEPTH-1, one per cycle, over exactly DEPTH cycles.
REQ-022 done SHALL pulse for exactly one cycle, in the first IDLE cycle after the last fill write.
REQ-023 fill_start and wren in the same IDLE cycle SHALL start the fill and drop the user write.
REQ-024 fill_start and wren SHALL both be ignored while busy=1.
REQ-025 q and q_addr SHALL hold their values while busy=1.
REQ-026 With scan_en=1, tick=1 and busy=0, the scan counter SHALL increment, wrapping DEPTH-1 to 0.
REQ-027 While scan_en=0 or busy=1, the scan counter SHALL hold.

Reset
REQ-028 With reset=1 at a clock edge, the FSM SHALL go to IDLE and q, q_addr, busy, done and the scan counter SHALL go to 0.
REQ-029 Reset SHALL NOT alter array contents; reset during a fill SHALL abort it, leaving words written so far and no done pulse.
REQ-030 Array contents after power-up SHALL be undefined until written or filled.

Configuration
REQ-031 With macro RAM_SEQUENCER_WRITE_THROUGH_EN defined, a user write to the current read address SHALL make q show the new data in the next cycle; without it, REQ-019 SHALL apply.

Structure
REQ-032 The FSM state encoding and default DATA_W/ADDR_W constants SHALL live in shared package ram_seq_pkg.
REQ-033 The storage SHALL be a sub-module ram_sp_array: single port, synchronous write, registered read, parametrised by DATA_W and ADDR_W.

Verification
REQ-034 The bench SHALL write 0x9 to address 0x13, then read 0x13: q=0x9 and q_addr=0x13 exactly one cycle after the read address is applied.
REQ-035 The bench SHALL pulse fill_start with fill_value=0xA: busy=1 for 32 cycles, done pulses once, and a full read-back returns 0xA at all 32 addresses.
REQ-036 The bench SHALL drive wren=1 to address 0x05 at fill cycle 10 and fill_start again mid-fill: both are ignored, address 0x05 reads 0xA, and only one done pulse occurs.
REQ-037 The bench SHALL assert reset after 8 fill cycles: busy=0, done=0, q=0 next cycle; addresses 0..7 hold the fill value and address 8 keeps its old value.
REQ-038 The bench SHALL run scan_en=1 with 33 tick pulses: q_addr steps 0..31 and then 0, each showing the stored word.
REQ-039 The bench SHALL write 0x3 to address 0x02 while reading 0x02: q shows the old word without RAM_SEQUENCER_WRITE_THROUGH_EN and 0x3 with it.

Source files
------------

// File: rtl/ram_seq_pkg.sv
// Shared constants and FSM encoding for the RAM sequencer.
// Imported by ram_sp_array and ram_sequencer.
package ram_seq_pkg;

   localparam int RAM_SEQ_DATA_W = 4;
   localparam int RAM_SEQ_ADDR_W = 5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } seq_state_e;

endpackage

// File: rtl/ram_sp_array.sv
// Word array: synchronous write, registered read with resettable output.
// Macro RAM_SEQUENCER_WRITE_THROUGH_EN forwards same-address write data to rdata_o.
module ram_sp_array
   import ram_seq_pkg::*;
#(
   parameter int DATA_W = RAM_SEQ_DATA_W,
   parameter int ADDR_W = RAM_SEQ_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic              bypass;

`ifdef RAM_SEQUENCER_WRITE_THROUGH_EN
   assign bypass = we_i && (waddr_i == raddr_i);
`else
   assign bypass = 1'b0;
`endif

   // Storage write; contents are never cleared so reset leaves them intact
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read; without bypass a colliding write returns the old word
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= bypass ? wdata_i : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sequencer.sv
// RAM with user read/write, whole-array fill sequencer and scan read counter.
// Macro RAM_SEQUENCER_WRITE_THROUGH_EN selects write-through read behaviour.
module ram_sequencer
   import ram_seq_pkg::*;
#(
   parameter int DATA_W = RAM_SEQ_DATA_W,
   parameter int ADDR_W = RAM_SEQ_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_value,
   input  logic              scan_en,
   input  logic              tick,
   output logic [DATA_W-1:0] q,
   output logic [ADDR_W-1:0] q_addr,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = '1;

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [DATA_W-1:0] fill_val_q, fill_val_d;
   logic [ADDR_W-1:0] scan_q, scan_d;
   logic [ADDR_W-1:0] q_addr_q, q_addr_d;
   logic              done_q, done_d;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr;
   logic              re;

   assign busy  = (state_q == S_FILL);
   assign raddr = scan_en ? scan_q : address;
   assign re    = !busy;

   // Next state, fill progress and write-port steering
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      fill_val_d = fill_val_q;
      done_d     = 1'b0;
      we         = 1'b0;
      waddr      = address;
      wdata      = data;
      unique case (state_q)
         S_IDLE: begin
            if (fill_start) begin
               state_d    = S_FILL;
               fill_cnt_d = '0;
               fill_val_d = fill_value;
            end else if (wren) begin
               we = !reset;
            end
         end
         S_FILL: begin
            we         = !reset;
            waddr      = fill_cnt_q;
            wdata      = fill_val_q;
            fill_cnt_d = fill_cnt_q + 1'b1;
            if (fill_cnt_q == LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Scan counter advances on tick and wraps naturally at DEPTH
   always_comb begin
      scan_d = scan_q;
      if (scan_en && tick && !busy) begin
         scan_d = scan_q + 1'b1;
      end
   end

   // q_addr tracks the read address only while reads are enabled
   always_comb begin
      q_addr_d = q_addr_q;
      if (re) begin
         q_addr_d = raddr;
      end
   end

   // Sequencer state registers; reset aborts any fill without a done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         fill_cnt_q <= '0;
         fill_val_q <= '0;
         scan_q     <= '0;
         q_addr_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         fill_val_q <= fill_val_d;
         scan_q     <= scan_d;
         q_addr_q   <= q_addr_d;
         done_q     <= done_d;
      end
   end

   ram_sp_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i   (clock),
      .rst_i   (reset),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .re_i    (re),
      .raddr_i (raddr),
      .rdata_o (q)
   );

   assign q_addr = q_addr_q;
   assign done   = done_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed bench for ram_sequencer: user r/w, fill, abort, scan, collision.
// Build with RAM_SEQUENCER_WRITE_THROUGH_EN to expect write-through reads.
module tb_ram_sequencer;

   localparam int DW = 4;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] address;
   logic [DW-1:0] data;
   logic          wren;
   logic          fill_start;
   logic [DW-1:0] fill_value;
   logic          scan_en;
   logic          tick;
   logic [DW-1:0] q;
   logic [AW-1:0] q_addr;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   ram_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .data       (data),
      .wren       (wren),
      .fill_start (fill_start),
      .fill_value (fill_value),
      .scan_en    (scan_en),
      .tick       (tick),
      .q          (q),
      .q_addr     (q_addr),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
      address = a;
      step;
      check({tag, "_q"}, 32'(q), 32'(e));
      check({tag, "_qaddr"}, 32'(q_addr), 32'(a));
   endtask

   function automatic logic [DW-1:0] scan_exp(input int a);
      if (a < 8) return 4'hC;
      if (a == 8) return 4'h5;
      return 4'hA;
   endfunction

   int busy_cnt;
   int done_cnt;
   int hold_bad;
   logic [DW-1:0] exp_col;

   initial begin
      reset = 1'b1; address = '0; data = '0; wren = 1'b0;
      fill_start = 1'b0; fill_value = '0; scan_en = 1'b0; tick = 1'b0;
      step;
      step;
      check("rst_q", 32'(q), 32'h0);
      check("rst_qaddr", 32'(q_addr), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      reset = 1'b0;

      // user write then read, latency 1
      address = 5'h13; data = 4'h9; wren = 1'b1;
      step;
      wren = 1'b0;
      rd("wr13", 5'h13, 4'h9);

      // full fill with 0xA; q must hold while busy
      fill_value = 4'hA; fill_start = 1'b1;
      step;
      fill_start = 1'b0;
      busy_cnt = 0; done_cnt = 0; hold_bad = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy) begin
            busy_cnt++;
            if (q !== 4'h9 || q_addr !== 5'h13) hold_bad++;
         end
         if (done) done_cnt++;
         step;
      end
      check("fill1_busy_cycles", 32'(busy_cnt), 32'd32);
      check("fill1_done_pulses", 32'(done_cnt), 32'd1);
      check("fill1_q_hold", 32'(hold_bad), 32'd0);
      for (int a = 0; a < 32; a++) rd("fill1_rb", 5'(a), 4'hA);

      // second fill with ignored wren and fill_start at fill cycle 10
      fill_value = 4'hA; fill_start = 1'b1;
      step;
      fill_start = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 50; k++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (k == 10) begin
            wren = 1'b1; address = 5'h05; data = 4'h1;
            fill_start = 1'b1; fill_value = 4'h7;
         end else begin
            wren = 1'b0; fill_start = 1'b0; fill_value = 4'hA;
         end
         step;
      end
      check("fill2_busy_cycles", 32'(busy_cnt), 32'd32);
      check("fill2_done_pulses", 32'(done_cnt), 32'd1);
      rd("fill2_a05", 5'h05, 4'hA);
      rd("fill2_a14", 5'h14, 4'hA);
      rd("fill2_a1f", 5'h1f, 4'hA);

      // reset after 8 fill cycles aborts the fill
      address = 5'h08; data = 4'h5; wren = 1'b1;
      step;
      wren = 1'b0;
      fill_value = 4'hC; fill_start = 1'b1;
      step;
      fill_start = 1'b0;
      repeat (8) step;
      reset = 1'b1;
      step;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_q", 32'(q), 32'h0);
      check("abort_qaddr", 32'(q_addr), 32'h0);
      reset = 1'b0;
      step;
      check("abort_no_done", 32'(done), 32'h0);
      check("abort_idle", 32'(busy), 32'h0);
      for (int a = 0; a < 10; a++) rd("abort_rb", 5'(a), scan_exp(a));

      // scan with 33 ticks, wrapping back to 0
      scan_en = 1'b1; tick = 1'b0;
      step;
      check("scan0_qaddr", 32'(q_addr), 32'h0);
      check("scan0_q", 32'(q), 32'(scan_exp(0)));
      for (int i = 1; i <= 33; i++) begin
         tick = 1'b1;
         step;
         tick = 1'b0;
         step;
         check("scan_qaddr", 32'(q_addr), 32'(i % 32));
         check("scan_q", 32'(q), 32'(scan_exp(i % 32)));
      end
      scan_en = 1'b0;

      // read-during-write collision on address 2
      rd("col_pre", 5'h02, 4'hC);
`ifdef RAM_SEQUENCER_WRITE_THROUGH_EN
      exp_col = 4'h3;
`else
      exp_col = 4'hC;
`endif
      address = 5'h02; data = 4'h3; wren = 1'b1;
      step;
      wren = 1'b0;
      check("col_q", 32'(q), 32'(exp_col));
      rd("col_post", 5'h02, 4'h3);

      // fill_start wins over wren in the same cycle
      address = 5'h13; data = 4'h1; wren = 1'b1;
      fill_value = 4'hE; fill_start = 1'b1;
      step;
      wren = 1'b0; fill_start = 1'b0;
      check("both_busy", 32'(busy), 32'h1);
      repeat (40) step;
      check("both_idle", 32'(busy), 32'h0);
      rd("both_a13", 5'h13, 4'hE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
